// File: rtl/apb_completer.sv
// APB completer with a small byte-strobed register file.
// Phase tracking IDLE -> SETUP -> ACCESS; transfer fields are latched when the
// requester presents the setup phase and only the latched copy is used after.
// Optional feature: define APB_WAIT_STATES_EN to insert WAIT_CYCLES wait
// states per transfer; otherwise PREADY rises in the first ACCESS cycle.
module apb_completer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    wait_done;
  logic                    err;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDX_W-1:0]        idx;

`ifdef APB_WAIT_STATES_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait counter: reload on every setup phase, count down through ACCESS.
  always_comb begin
    cnt_d = cnt_q;
    if (PSEL && !PENABLE)
      cnt_d = CNT_W'(WAIT_CYCLES);
    else if (state_q == ACCESS && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge PCLK) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wait_done = (cnt_q == '0);
`else
  assign wait_done = 1'b1;
`endif

  // Address decode and error classification on the latched transfer.
  assign off      = addr_q - BASE_ADDR;
  assign idx_full = off >> LSB;
  assign idx      = idx_full[IDX_W-1:0];
  assign err      = ((addr_q & ALIGN_MASK) != '0)
                 || (addr_q < BASE_ADDR)
                 || (idx_full >= ADDR_WIDTH'(NUM_REGS))
                 || (!write_q && (strb_q != '0));

  assign PREADY  = (state_q == ACCESS) && PSEL && PENABLE && wait_done;
  assign PSLVERR = PREADY && err;
  assign commit  = PREADY && !err && write_q;
  assign PRDATA  = (PREADY && !err && !write_q) ? regs_q[idx] : '0;

  // Next phase, field latching and byte-lane register writes.
  // A setup phase seen in any state restarts the transfer; PSEL+PENABLE in
  // IDLE is a protocol violation and is ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    regs_d  = regs_q;
    if (!PSEL) begin
      state_d = IDLE;
    end else if (!PENABLE) begin
      state_d = SETUP;
      addr_d  = PADDR;
      write_d = PWRITE;
      wdata_d = PWDATA;
      strb_d  = PSTRB;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SETUP:   state_d = ACCESS;
        ACCESS:  state_d = PREADY ? IDLE : ACCESS;
        default: state_d = IDLE;
      endcase
    end
    if (commit) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (strb_q[b]) regs_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Phase FSM, latched fields and register file; reset discards any transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_apb_completer.sv
// Self-checking bench for apb_completer: directed scenarios followed by
// random transfers compared against a transfer-level register model.
module tb_apb_completer;
`ifdef APB_WAIT_STATES_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [16];

  apb_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
    .BASE_ADDR(32'h0), .WAIT_CYCLES(2)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfer-level expectation: decode by plain address arithmetic.
  task automatic model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] exp_rd, output logic exp_err);
    int unsigned word;
    word    = a / 4;
    exp_err = (a % 4 != 0) || (word >= 16) || (!wr && s != 4'h0);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model[word][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_rd = model[word];
      end
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) model[r] = '0;
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // One APB transfer; returns at the falling edge of the PREADY cycle so the
  // next call can issue its setup phase back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err,
                      output int stalls, output logic side_bad);
    bit done;
    done = 0; stalls = 0; side_bad = 0; rd = '0; err = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    @(negedge PCLK);
    if (PREADY || PSLVERR || PRDATA != 0) side_bad = 1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    // completer must use latched fields, so the bus is scrambled here
    PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom); PWRITE = 1'($urandom);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        done = 1; rd = PRDATA; err = PSLVERR;
      end else begin
        stalls++;
        if (PSLVERR || PRDATA != 0) side_bad = 1;
      end
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err, side_bad;
    int          stalls;
    model_xfer(wr, a, d, s, exp_rd, exp_err);
    xfer(wr, a, d, s, rd, err, stalls, side_bad);
    check({tag, ".prdata"}, rd, exp_rd);
    check({tag, ".pslverr"}, 32'(err), 32'(exp_err));
    check({tag, ".waits"}, 32'(stalls), 32'(1 + EXP_WAIT));
    check({tag, ".quiet"}, 32'(side_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        wr;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    model_clear();
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rst.pready", 32'(PREADY), 32'd0);
    check("rst.pslverr", 32'(PSLVERR), 32'd0);
    check("rst.prdata", PRDATA, 32'd0);

    // full-word write and readback
    run("wr04", 1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    run("rd04", 1'b0, 32'h04, 32'h0, 4'h0);
    check("rd04.value", model[1], 32'hDEADBEEF);
    idle();

    // partial strobes over zero
    run("wr08", 1'b1, 32'h08, 32'h11223344, 4'b0101);
    idle();
    run("rd08", 1'b0, 32'h08, 32'h0, 4'h0);
    check("rd08.value", model[2], 32'h00220044);

    // decode errors, strobe-on-read error, zero-strobe write
    run("wr06", 1'b1, 32'h06, 32'hCAFEF00D, 4'hF);
    run("wr40", 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    run("rdstrb", 1'b0, 32'h04, 32'h0, 4'h2);
    run("wrz", 1'b1, 32'h04, 32'h12345678, 4'h0);
    run("rd04b", 1'b0, 32'h04, 32'h0, 4'h0);
    idle();

    // PSEL+PENABLE straight from IDLE is ignored
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h12345678; PSTRB = 4'hF;
    @(negedge PCLK);
    check("viol.c1", 32'(PREADY), 32'd0);
    @(negedge PCLK);
    check("viol.c2", 32'(PREADY), 32'd0);
    idle();
    run("viol.rd", 1'b0, 32'h00, 32'h0, 4'h0);
    idle();

    // PSEL dropped in the first ACCESS cycle aborts the write
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("abort.pready", 32'(PREADY), 32'd0);
    run("abort.rd", 1'b0, 32'h0C, 32'h0, 4'h0);
    idle();

    // random traffic, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a  = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 127));
      d  = $urandom;
      s  = wr ? 4'($urandom) : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      run($sformatf("rnd%0d", n), wr, a, d, s);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // reset while a write is in flight
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_clear();
    @(negedge PCLK);
    check("mrst.pready", 32'(PREADY), 32'd0);
    check("mrst.pslverr", 32'(PSLVERR), 32'd0);
    check("mrst.prdata", PRDATA, 32'd0);
    check("mrst.state", 32'(dut.state_q), 32'd0);
    run("mrst.rd00", 1'b0, 32'h00, 32'h0, 4'h0);
    run("mrst.rd04", 1'b0, 32'h04, 32'h0, 4'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
